// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel framebuffer slice.
// Holds the default colour codes, the RAM word width and the state and slot
// enumerations used by the arbiter.
package pixel_pkg;

  // Width of one RAM word. Colour codes sit in the low bits.
  localparam int unsigned RAM_W = 16;

  // Default colour codes.
  localparam int unsigned DEF_CLEAR_COLOR   = 0;
  localparam int unsigned DEF_OUTSIDE_COLOR = 7;

  typedef enum logic {
    FB_CLEAR,
    FB_RUN
  } fb_state_t;

  typedef enum logic {
    SLOT_READ,
    SLOT_WRITE
  } slot_t;

endpackage

// File: rtl/pixel_sp_ram.sv
// Synchronous single-port RAM with a one-cycle registered read.
// Behavioural model; the target maps it onto a single-port RAM primitive.
// Ports:
//   clk   in   1       clock
//   we    in   1       write enable
//   addr  in   ADDR_W  word address, shared by read and write
//   wdata in   DATA_W  write data
//   rdata out  DATA_W  data at the address presented on the previous cycle
module pixel_sp_ram #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: sequential state is assigned with <= so every flop samples its
  // inputs as they were before the clock edge.
  // NOTE: the array has no reset; a reset port would stop it mapping onto a
  // RAM block. Its contents are initialised by the clear sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pixel_frame_buffer.sv
// Single-port framebuffer between the brush/command path and VGA scan-out.
// The RAM alternates READ and WRITE slots. Scan-out reads use the READ
// slots. Queued brush writes drain one per WRITE slot. A clear sweep writes
// CLEAR_COLOR to every address, one per cycle, and owns the RAM until it ends.
// Ports:
//   clk        in   1         system clock (2x pixel rate)
//   reset      in   1         synchronous, active-high
//   clear_req  in   1         pulse: start a full-frame clear sweep
//   wr_valid   in   1         brush write request valid
//   wr_ready   out  1         write FIFO can accept an entry
//   wr_x/wr_y  in   COORD_W   write column / row
//   wr_color   in   COLOR_W   write colour
//   rx/ry      in   SCREEN_W  scan-out column / row
//   color_code out  COLOR_W   colour of the pixel sampled 2 cycles earlier
//   busy       out  1         high while a clear sweep runs
module pixel_frame_buffer
  import pixel_pkg::*;
#(
  parameter int unsigned COORD_W       = 7,
  parameter int unsigned COLOR_W       = 3,
  parameter int unsigned SCREEN_W      = 10,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CLEAR_COLOR   = DEF_CLEAR_COLOR,
  parameter int unsigned OUTSIDE_COLOR = DEF_OUTSIDE_COLOR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [COORD_W-1:0]  wr_x,
  input  logic [COORD_W-1:0]  wr_y,
  input  logic [COLOR_W-1:0]  wr_color,
  input  logic [SCREEN_W-1:0] rx,
  input  logic [SCREEN_W-1:0] ry,
  output logic [COLOR_W-1:0]  color_code,
  output logic                busy
);

  localparam int unsigned ADDR_W = 2 * COORD_W;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = '1;
  localparam logic [SCREEN_W-1:0] GRID_N    = SCREEN_W'(2 ** COORD_W);

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    logic [COLOR_W-1:0] color;
  } wr_entry_t;

  fb_state_t         state_q, state_d;
  slot_t             phase_q, phase_d;
  logic [ADDR_W-1:0] count_q, count_d;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  wr_entry_t         fifo_mem_q [FIFO_DEPTH];
  wr_entry_t         fifo_mem_d [FIFO_DEPTH];

  logic              rd_valid_q, rd_valid_d;
  logic              outside_q, outside_d;
  logic [COLOR_W-1:0] color_code_q, color_code_d;

  logic              fifo_empty, fifo_full, push, pop;
  wr_entry_t         head;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [RAM_W-1:0]  ram_wdata, ram_rdata;
  logic              unused_rdata;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push       = wr_valid && !fifo_full;
  assign pop        = (state_q == FB_RUN) && (phase_q == SLOT_WRITE) && !fifo_empty;
  assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  // Arbiter: next state, sweep counter, slot phase and RAM port mux.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    count_d   = count_q;
    ram_we    = 1'b0;
    ram_addr  = count_q;
    ram_wdata = RAM_W'(COLOR_W'(CLEAR_COLOR));
    case (state_q)
      FB_CLEAR: begin
        ram_we  = 1'b1;
        phase_d = SLOT_READ;   // RUN always starts with a READ slot
        if (clear_req) begin
          count_d = '0;
        end else if (count_q == LAST_ADDR) begin
          state_d = FB_RUN;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      FB_RUN: begin
        phase_d = (phase_q == SLOT_READ) ? SLOT_WRITE : SLOT_READ;
        if (phase_q == SLOT_READ) begin
          ram_addr = {ry[COORD_W-1:0], rx[COORD_W-1:0]};
        end else begin
          ram_addr  = {head.y, head.x};
          ram_we    = pop;
          ram_wdata = RAM_W'(head.color);
        end
        if (clear_req) begin
          state_d = FB_CLEAR;
          count_d = '0;
        end
      end
      default: state_d = FB_CLEAR;
    endcase
  end

  // Write FIFO: push whenever there is room, pop only in RUN WRITE slots.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);
    fifo_mem_d = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = '{y: wr_y, x: wr_x, color: wr_color};
    end
  end

  // Read pipeline: the outside flag travels with the RAM read so that
  // color_code reflects the same scan position two cycles later.
  always_comb begin
    rd_valid_d   = (state_q == FB_RUN) && (phase_q == SLOT_READ);
    outside_d    = (rx >= GRID_N) || (ry >= GRID_N);
    color_code_d = color_code_q;
    if (rd_valid_q) begin
      color_code_d = outside_q ? COLOR_W'(OUTSIDE_COLOR) : ram_rdata[COLOR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FB_CLEAR;
      phase_q      <= SLOT_READ;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_valid_q   <= 1'b0;
      outside_q    <= 1'b0;
      color_code_q <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_valid_q   <= rd_valid_d;
      outside_q    <= outside_d;
      color_code_q <= color_code_d;
    end
  end

  // Entry storage is only ever read between the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  pixel_sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (RAM_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Only the low COLOR_W bits of a word carry colour.
  assign unused_rdata = ^ram_rdata;

  assign wr_ready   = !fifo_full;
  assign busy       = (state_q == FB_CLEAR);
  assign color_code = color_code_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Self-checking bench for pixel_frame_buffer.
// A transaction-level reference model (pixel array, write queue, and a
// cycle count since the sweep ended) predicts busy, wr_ready and color_code
// every cycle. Directed steps add explicit checks for the named scenarios.
module tb_pixel_frame_buffer;

  localparam int COORD_W = 7;
  localparam int COLOR_W = 3;
  localparam int GRID    = 1 << COORD_W;
  localparam int NPIX    = GRID * GRID;
  localparam int DEPTH   = 4;

  logic                clk = 1'b0;
  logic                reset, clear_req, wr_valid, wr_ready, busy;
  logic [COORD_W-1:0]  wr_x, wr_y;
  logic [COLOR_W-1:0]  wr_color, color_code;
  logic [9:0]          rx, ry;

  pixel_frame_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_color   (wr_color),
    .rx         (rx),
    .ry         (ry),
    .color_code (color_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  typedef struct { int x; int y; int c; } wr_t;
  wr_t  m_q[$];
  int   m_mem [NPIX];
  bit   m_busy;
  int   m_cnt;
  int   m_run;
  int   m_color;
  bit   m_p_valid;
  int   m_p_val;
  bit   checking = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one cycle using the inputs driven in this cycle.
  task automatic model_step();
    int  size0;
    bit  rd_v;
    int  rd_val;
    wr_t e;
    if (reset) begin
      m_q.delete();
      m_busy    = 1'b1;
      m_cnt     = 0;
      m_color   = 0;
      m_p_valid = 1'b0;
      checking  = 1'b1;
      return;
    end
    size0  = m_q.size();
    rd_v   = 1'b0;
    rd_val = 0;
    if (!m_busy) begin
      if (m_run % 2 == 0) begin
        rd_v = 1'b1;
        if (int'(rx) >= GRID || int'(ry) >= GRID) rd_val = 7;
        else rd_val = m_mem[int'(ry) * GRID + int'(rx)];
      end else if (size0 > 0) begin
        e = m_q.pop_front();
        m_mem[e.y * GRID + e.x] = e.c;
      end
    end
    if (wr_valid && size0 < DEPTH) begin
      e.x = int'(wr_x); e.y = int'(wr_y); e.c = int'(wr_color);
      m_q.push_back(e);
    end
    // Read result appears on color_code two cycles after its READ slot.
    if (m_p_valid) m_color = m_p_val;
    m_p_valid = rd_v;
    m_p_val   = rd_val;
    if (!m_busy) begin
      if (clear_req) begin m_busy = 1'b1; m_cnt = 0; end
      else m_run++;
    end else if (clear_req) begin
      m_cnt = 0;
    end else if (m_cnt == NPIX - 1) begin
      m_busy = 1'b0;
      m_run  = 0;
      foreach (m_mem[i]) m_mem[i] = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock: check outputs at the falling edge, step the model, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic tick();
    @(negedge clk);
    if (checking) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("wr_ready", {31'b0, wr_ready}, (m_q.size() < DEPTH) ? 1 : 0);
      check("color_code", {29'b0, color_code}, m_color);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid  = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic push_one(input int x, input int y, input int c);
    wr_x = COORD_W'(x); wr_y = COORD_W'(y); wr_color = COLOR_W'(c);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_px(input int x, input int y, output int v);
    rx = 10'(x); ry = 10'(y);
    repeat (4) tick();
    v = int'(color_code);
  endtask

  // Run until busy drops with idle inputs; returns the number of busy cycles.
  task automatic run_sweep(output int n);
    n = 0;
    for (int i = 0; i < 20000; i++) begin
      if (busy !== 1'b1) break;
      n++;
      rx = 10'($urandom_range(0, 300));
      ry = 10'($urandom_range(0, 300));
      tick();
    end
  endtask

  initial begin
    int v, n, acc, c77;
    int xs [4];
    int cs [4];

    reset = 1'b1; idle();
    wr_x = '0; wr_y = '0; wr_color = '0; rx = '0; ry = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 1);
    check("rst_ready", {31'b0, wr_ready}, 1);
    check("rst_color", {29'b0, color_code}, 0);

    // Initial sweep, with wr_valid held 10 cycles partway through.
    xs[0] = 10; xs[1] = 11; xs[2] = 10; xs[3] = 12;
    for (int i = 0; i < 4; i++) cs[i] = $urandom_range(1, 7);
    n = 0; acc = 0;
    for (int i = 0; i < 20000; i++) begin
      if (busy !== 1'b1) break;
      n++;
      wr_valid = (i >= 50 && i < 60);
      wr_x = COORD_W'(xs[(acc < 4) ? acc : 3]); wr_y = 7'd20;
      wr_color = COLOR_W'(cs[(acc < 4) ? acc : 3]);
      if (wr_valid && wr_ready) acc++;
      rx = 10'($urandom_range(0, 300)); ry = 10'($urandom_range(0, 300));
      tick();
    end
    idle();
    check("clear_len", n, NPIX);
    check("accepted", acc, 4);
    check("ready_full", {31'b0, wr_ready}, 0);

    // Random reads of the cleared frame (queued writes drain meanwhile).
    for (int i = 0; i < 300; i++) begin
      rx = 10'($urandom_range(0, GRID - 1)); ry = 10'($urandom_range(0, GRID - 1));
      tick();
    end
    read_px(0, 0, v);       check("clr_0_0", v, 0);
    read_px(127, 0, v);     check("clr_127_0", v, 0);
    read_px(10, 20, v);     check("order_10_20", v, cs[2]);
    read_px(11, 20, v);     check("order_11_20", v, cs[1]);
    read_px(12, 20, v);     check("order_12_20", v, cs[3]);

    // Single write, neighbour, out-of-grid and corner.
    push_one(5, 9, 2);
    repeat (4) tick();
    read_px(5, 9, v);       check("px_5_9", v, 2);
    read_px(6, 9, v);       check("px_6_9", v, 0);
    read_px(128, 3, v);     check("out_x", v, 7);
    read_px(3, 200, v);     check("out_y", v, 7);
    c77 = $urandom_range(1, 6);
    push_one(127, 127, c77);
    repeat (4) tick();
    read_px(127, 127, v);   check("px_127_127", v, c77);

    // Random mix of writes and reads in a small window.
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_x = COORD_W'($urandom_range(0, 7)); wr_y = COORD_W'($urandom_range(0, 7));
      wr_color = COLOR_W'($urandom);
      if ($urandom_range(0, 15) == 0) rx = 10'(GRID + $urandom_range(0, 500));
      else rx = 10'($urandom_range(0, 7));
      ry = 10'($urandom_range(0, 7));
      tick();
    end
    idle();
    repeat (12) tick();

    // Clear with a write queued mid-sweep.
    push_one(1, 1, 4);
    repeat (6) tick();
    read_px(1, 1, v);       check("px_1_1", v, 4);
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    repeat (100) tick();
    push_one(2, 2, 6);
    run_sweep(n);
    check("sweep2_end", {31'b0, busy}, 0);
    repeat (4) tick();
    read_px(1, 1, v);       check("clr_1_1", v, 0);
    read_px(2, 2, v);       check("post_2_2", v, 6);

    // Reset mid-sweep with two entries queued.
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    repeat (50) tick();
    push_one(20, 30, 5);
    push_one(21, 30, 3);
    repeat (10) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2_ready", {31'b0, wr_ready}, 1);
    check("rst2_color", {29'b0, color_code}, 0);
    run_sweep(n);
    check("rst_sweep_len", n, NPIX);
    repeat (4) tick();
    read_px(20, 30, v);     check("flush_20_30", v, 0);
    read_px(21, 30, v);     check("flush_21_30", v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
